// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// Arbitrates memory wait, MUL/DIV latency, branch redirect and load-use.
module pipe_stall_ctrl #(
  parameter int DIV_CYCLES = 33,
  parameter int MUL_CYCLES = 2,
  parameter int MEM_TO     = 16,
  parameter int CNT_W      = 6
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        ld_use_hazard,
  input  logic        br_taken,
  input  logic        mdu_req,
  input  logic        mdu_is_div,
  input  logic        dmem_req,
  input  logic        dmem_ready,
  output logic        pc_we,
  output logic        ifid_we,
  output logic        idex_we,
  output logic        exmem_we,
  output logic        memwb_we,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        exmem_flush,
  output logic        memwb_flush,
  output logic        mdu_start,
  output logic        mdu_busy,
  output logic        bus_err,
  output logic [15:0] stall_cnt
);

  typedef enum logic [1:0] {
    RUN,
    MDU,
    MEM_WAIT,
    ERR
  } state_t;

  localparam logic [CNT_W-1:0] DIV_LAT = CNT_W'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] MUL_LAT = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_MAX = CNT_W'(MEM_TO);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] tmo;
  logic             mem_miss;

  assign mem_miss = dmem_req && !dmem_ready;

  always_comb begin
    pc_we       = 1'b1;
    ifid_we     = 1'b1;
    idex_we     = 1'b1;
    exmem_we    = 1'b1;
    memwb_we    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;
    mdu_start   = 1'b0;
    mdu_busy    = 1'b0;
    unique case (state)
      RUN: begin
        if (mem_miss) begin
          pc_we       = 1'b0;
          ifid_we     = 1'b0;
          idex_we     = 1'b0;
          exmem_we    = 1'b0;
          memwb_flush = 1'b1;
        end else if (mdu_req) begin
          mdu_start   = 1'b1;
          pc_we       = 1'b0;
          ifid_we     = 1'b0;
          idex_we     = 1'b0;
          exmem_flush = 1'b1;
        end else if (br_taken) begin
          ifid_flush  = 1'b1;
          idex_flush  = 1'b1;
        end else if (ld_use_hazard) begin
          pc_we       = 1'b0;
          ifid_we     = 1'b0;
          idex_flush  = 1'b1;
        end
      end
      MDU: begin
        mdu_busy = 1'b1;
        if (cnt != '0) begin
          pc_we       = 1'b0;
          ifid_we     = 1'b0;
          idex_we     = 1'b0;
          exmem_flush = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (!dmem_ready) begin
          pc_we       = 1'b0;
          ifid_we     = 1'b0;
          idex_we     = 1'b0;
          exmem_we    = 1'b0;
          memwb_flush = 1'b1;
        end
      end
      ERR: begin
        pc_we    = 1'b0;
        ifid_we  = 1'b0;
        idex_we  = 1'b0;
        exmem_we = 1'b0;
        memwb_we = 1'b0;
      end
      default: ;
    endcase
    // Pipeline is frozen and silent for as long as reset is held.
    if (!rstn) begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      idex_we     = 1'b0;
      exmem_we    = 1'b0;
      memwb_we    = 1'b0;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      exmem_flush = 1'b0;
      memwb_flush = 1'b0;
      mdu_start   = 1'b0;
      mdu_busy    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= RUN;
      cnt     <= '0;
      tmo     <= '0;
      bus_err <= 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          if (mem_miss) begin
            tmo   <= CNT_ONE;
            state <= MEM_WAIT;
          end else if (mdu_req) begin
            cnt   <= mdu_is_div ? DIV_LAT : MUL_LAT;
            state <= MDU;
          end
        end
        MDU: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_ONE;
          end else begin
            state <= RUN;
          end
        end
        MEM_WAIT: begin
          if (dmem_ready) begin
            state <= RUN;
          end else if (tmo == TMO_MAX) begin
            bus_err <= 1'b1;
            state   <= ERR;
          end else begin
            tmo <= tmo + CNT_ONE;
          end
        end
        ERR: ;
        default: state <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cnt <= '0;
    end else if (!pc_we && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl.
// Inputs change just after negedge; outputs are sampled 1ns later.
module tb_pipe_stall_ctrl;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        ld_use_hazard = 1'b0;
  logic        br_taken = 1'b0;
  logic        mdu_req = 1'b0;
  logic        mdu_is_div = 1'b0;
  logic        dmem_req = 1'b0;
  logic        dmem_ready = 1'b0;
  logic        pc_we, ifid_we, idex_we, exmem_we, memwb_we;
  logic        ifid_flush, idex_flush, exmem_flush, memwb_flush;
  logic        mdu_start, mdu_busy, bus_err;
  logic [15:0] stall_cnt;
  logic [4:0]  we;
  logic [3:0]  fl;

  int n_chk = 0;
  int n_err = 0;
  int stalls;
  int starts;

  always #5 clk = ~clk;

  pipe_stall_ctrl dut (
    .clk           (clk),
    .rstn          (rstn),
    .ld_use_hazard (ld_use_hazard),
    .br_taken      (br_taken),
    .mdu_req       (mdu_req),
    .mdu_is_div    (mdu_is_div),
    .dmem_req      (dmem_req),
    .dmem_ready    (dmem_ready),
    .pc_we         (pc_we),
    .ifid_we       (ifid_we),
    .idex_we       (idex_we),
    .exmem_we      (exmem_we),
    .memwb_we      (memwb_we),
    .ifid_flush    (ifid_flush),
    .idex_flush    (idex_flush),
    .exmem_flush   (exmem_flush),
    .memwb_flush   (memwb_flush),
    .mdu_start     (mdu_start),
    .mdu_busy      (mdu_busy),
    .bus_err       (bus_err),
    .stall_cnt     (stall_cnt)
  );

  assign we = {pc_we, ifid_we, idex_we, exmem_we, memwb_we};
  assign fl = {ifid_flush, idex_flush, exmem_flush, memwb_flush};

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  initial begin
    @(negedge clk); #1;
    chk("rst_we", 32'(we), 32'h00);
    chk("rst_fl", 32'(fl), 32'h0);
    chk("rst_start", 32'(mdu_start), 32'h0);
    chk("rst_busy", 32'(mdu_busy), 32'h0);
    chk("rst_cnt", 32'(stall_cnt), 32'd0);
    chk("rst_err", 32'(bus_err), 32'h0);
    @(negedge clk); rstn = 1'b1;

    // T1 load-use
    @(negedge clk); ld_use_hazard = 1'b1; #1;
    chk("t1_we", 32'(we), 32'(5'b00111));
    chk("t1_fl", 32'(fl), 32'(4'b0100));
    chk("t1_cnt0", 32'(stall_cnt), 32'd0);
    @(negedge clk); ld_use_hazard = 1'b0; #1;
    chk("t1_rel", 32'(we), 32'(5'b11111));
    chk("t1_cnt1", 32'(stall_cnt), 32'd1);

    // T2 branch beats load-use
    @(negedge clk); br_taken = 1'b1; ld_use_hazard = 1'b1; #1;
    chk("t2_we", 32'(we), 32'(5'b11111));
    chk("t2_fl", 32'(fl), 32'(4'b1100));
    @(negedge clk); br_taken = 1'b0; ld_use_hazard = 1'b0; #1;
    chk("t2_cnt", 32'(stall_cnt), 32'd1);

    // T3 divide: 33 stall cycles then release
    @(negedge clk); mdu_req = 1'b1; mdu_is_div = 1'b1; #1;
    chk("t3_start", 32'(mdu_start), 32'h1);
    chk("t3_we", 32'(we), 32'(5'b00011));
    chk("t3_fl", 32'(fl), 32'(4'b0010));
    stalls = 0;
    starts = 0;
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk); mdu_req = 1'b0; mdu_is_div = 1'b0; #1;
      if (!pc_we) stalls++;
      if (mdu_start) starts++;
    end
    @(negedge clk); #1;
    chk("t3_rel", 32'(we), 32'(5'b11111));
    chk("t3_busy", 32'(mdu_busy), 32'h1);
    chk("t3_stalls", 32'(stalls), 32'd32);
    chk("t3_starts", 32'(starts), 32'd0);
    @(negedge clk); #1;
    chk("t3_cnt", 32'(stall_cnt), 32'd34);
    chk("t3_idle", 32'(mdu_busy), 32'h0);

    // T3 multiply: 2 stall cycles
    @(negedge clk); mdu_req = 1'b1; #1;
    chk("t3m_start", 32'(mdu_start), 32'h1);
    chk("t3m_we0", 32'(we), 32'(5'b00011));
    @(negedge clk); mdu_req = 1'b0; #1;
    chk("t3m_we1", 32'(we), 32'(5'b00011));
    chk("t3m_nostart", 32'(mdu_start), 32'h0);
    @(negedge clk); #1;
    chk("t3m_rel", 32'(we), 32'(5'b11111));
    @(negedge clk); #1;
    chk("t3m_cnt", 32'(stall_cnt), 32'd36);

    // T4 memory wait of 3 cycles
    @(negedge clk); dmem_req = 1'b1; dmem_ready = 1'b0; #1;
    chk("t4_we0", 32'(we), 32'(5'b00001));
    chk("t4_fl0", 32'(fl), 32'(4'b0001));
    for (int i = 1; i <= 2; i++) begin
      @(negedge clk); #1;
      chk("t4_wait", 32'({we, fl}), 32'({5'b00001, 4'b0001}));
    end
    @(negedge clk); dmem_ready = 1'b1; #1;
    chk("t4_rel", 32'({we, fl}), 32'({5'b11111, 4'b0000}));
    @(negedge clk); dmem_req = 1'b0; dmem_ready = 1'b0; #1;
    chk("t4_run", 32'(we), 32'(5'b11111));
    chk("t4_cnt", 32'(stall_cnt), 32'd39);

    // T5 memory timeout
    @(negedge clk); dmem_req = 1'b1; #1;
    stalls = 0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk); #1;
      if (!pc_we && !exmem_we) stalls++;
    end
    chk("t5_wait", 32'(stalls), 32'd16);
    chk("t5_noerr", 32'(bus_err), 32'h0);
    @(negedge clk); #1;
    chk("t5_err", 32'(bus_err), 32'h1);
    chk("t5_we", 32'(we), 32'h00);
    chk("t5_fl", 32'(fl), 32'h0);
    chk("t5_cnt", 32'(stall_cnt), 32'd56);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk); dmem_ready = 1'b1; #1;
      chk("t5_stuck", 32'(we), 32'h00);
    end
    chk("t5_cnt2", 32'(stall_cnt), 32'd59);
    chk("t5_sticky", 32'(bus_err), 32'h1);
    @(negedge clk); rstn = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0; #1;
    chk("t5_rst_err", 32'(bus_err), 32'h0);
    chk("t5_rst_cnt", 32'(stall_cnt), 32'd0);
    @(negedge clk); rstn = 1'b1; #1;
    chk("t5_run", 32'(we), 32'(5'b11111));

    // T6 reset in the middle of a divide
    @(negedge clk); mdu_req = 1'b1; mdu_is_div = 1'b1; #1;
    chk("t6_start", 32'(mdu_start), 32'h1);
    for (int i = 2; i <= 10; i++) begin
      @(negedge clk); mdu_req = 1'b0; mdu_is_div = 1'b0;
    end
    #1;
    chk("t6_busy", 32'(mdu_busy), 32'h1);
    rstn = 1'b0; #1;
    chk("t6_we", 32'(we), 32'h00);
    chk("t6_busy0", 32'(mdu_busy), 32'h0);
    chk("t6_cnt", 32'(stall_cnt), 32'd0);
    @(negedge clk); rstn = 1'b1; #1;
    chk("t6_run", 32'(we), 32'(5'b11111));
    chk("t6_nostart", 32'(mdu_start), 32'h0);
    @(negedge clk); #1;
    chk("t6_cnt2", 32'(stall_cnt), 32'd0);
    chk("t6_idle", 32'(mdu_busy), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
